// File: rtl/im_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words,
// writes them sequentially from address 0, and holds the CPU in reset until a load completes.
module im_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   count_q, count_nxt;
    logic [ADDR_WIDTH-1:0] widx_q, widx_nxt;
    logic [1:0]            bcnt_q, bcnt_nxt;
    logic [23:0]           acc_q, acc_nxt;
    logic                  rx_ready_nxt, im_we_nxt, cpu_reset_nxt, busy_nxt, done_nxt, error_nxt;
    logic [ADDR_WIDTH-1:0] im_addr_nxt;
    logic [31:0]           im_wdata_nxt;
    logic                  last_word;

    assign last_word = ({1'b0, widx_q} + (ADDR_WIDTH+1)'(1)) == count_q;

    always_comb begin
        state_nxt     = state;
        count_nxt     = count_q;
        widx_nxt      = widx_q;
        bcnt_nxt      = bcnt_q;
        acc_nxt       = acc_q;
        im_we_nxt     = 1'b0;
        im_addr_nxt   = im_addr;
        im_wdata_nxt  = im_wdata;
        cpu_reset_nxt = cpu_reset;
        error_nxt     = error;

        case (state)
            IDLE: begin
                if (start) begin
                    cpu_reset_nxt = 1'b1;
                    error_nxt     = 1'b0;
                    if (word_count == '0) begin
                        state_nxt = DONE;
                    end else if (word_count > DEPTH_W) begin
                        state_nxt = ERR;
                        error_nxt = 1'b1;
                    end else begin
                        count_nxt = word_count;
                        widx_nxt  = '0;
                        bcnt_nxt  = '0;
                        state_nxt = RECV;
                    end
                end
            end
            RECV: begin
                if (rx_valid && rx_ready) begin
                    bcnt_nxt = bcnt_q + 2'd1;
                    case (bcnt_q)
                        2'd0: acc_nxt[23:16] = rx_data;
                        2'd1: acc_nxt[15:8]  = rx_data;
                        2'd2: acc_nxt[7:0]   = rx_data;
                        default: begin
                            // Last byte goes straight into the write data; no extra cycle.
                            im_we_nxt    = 1'b1;
                            im_addr_nxt  = widx_q;
                            im_wdata_nxt = {acc_q, rx_data};
                            state_nxt    = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_nxt = DONE;
                end else begin
                    widx_nxt  = widx_q + ADDR_WIDTH'(1);
                    bcnt_nxt  = '0;
                    state_nxt = RECV;
                end
            end
            DONE: begin
                cpu_reset_nxt = 1'b0;
                state_nxt     = IDLE;
            end
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        rx_ready_nxt = (state_nxt == RECV);
        busy_nxt     = (state_nxt == RECV) || (state_nxt == WRITE);
        done_nxt     = (state_nxt == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count_q   <= '0;
            widx_q    <= '0;
            bcnt_q    <= '0;
            acc_q     <= '0;
            rx_ready  <= 1'b0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            count_q   <= count_nxt;
            widx_q    <= widx_nxt;
            bcnt_q    <= bcnt_nxt;
            acc_q     <= acc_nxt;
            rx_ready  <= rx_ready_nxt;
            im_we     <= im_we_nxt;
            im_addr   <= im_addr_nxt;
            im_wdata  <= im_wdata_nxt;
            cpu_reset <= cpu_reset_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: random byte streams against a byte-list model of the expected writes.
module tb_im_loader;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clock = 1'b0;
    logic          reset, start, rx_valid;
    logic [AW:0]   word_count;
    logic [7:0]    rx_data;
    logic          rx_ready, im_we, cpu_reset, busy, done, error;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;

    im_loader #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .word_count(word_count),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int passes = 0, checks = 0, fails = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, sess_cyc = 0, sess_done0 = 0;
    logic [39:0] got[$];
    int          got_cyc[$];
    logic [7:0]  tx_bytes[$];
    int          tx_gap[$];

    // Write/done monitor, sampled mid-cycle.
    always @(negedge clock) begin
        cyc++;
        if (im_we) begin
            got.push_back({im_addr, im_wdata});
            got_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic gen_tx(input int n, input int gapmax);
        tx_bytes.delete();
        tx_gap.delete();
        for (int i = 0; i < 4 * n; i++) begin
            tx_bytes.push_back(8'($urandom_range(255, 0)));
            tx_gap.push_back(gapmax == 0 ? 0 : int'($urandom_range(gapmax, 0)));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k = 0;
        while (!rx_ready && k < 50) begin
            tick;
            k++;
        end
        if (k >= 50) chk("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
        repeat (gap) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            tick;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tick;
        rx_valid = 1'b0;
    endtask

    task automatic feed(input int lo, input int hi);
        for (int i = lo; i < hi; i++) send_byte(tx_bytes[i], tx_gap[i]);
    endtask

    task automatic begin_load(input int n);
        got.delete();
        got_cyc.delete();
        sess_done0 = done_cnt;
        start = 1'b1;
        word_count = n[AW:0];
        tick;
        start = 1'b0;
        sess_cyc = cyc;
        chk("start_outputs", {60'd0, busy, rx_ready, cpu_reset, error}, 64'b1110);
    endtask

    // Expected write i is bytes 4i..4i+3 taken most-significant first, at address i.
    task automatic verify(input string tag, input int n);
        logic [31:0] w;
        chk({tag, "_nwrites"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            w = 32'(tx_bytes[4*i]) * 32'h0100_0000 + 32'(tx_bytes[4*i+1]) * 32'h1_0000
              + 32'(tx_bytes[4*i+2]) * 32'h100 + 32'(tx_bytes[4*i+3]);
            chk({tag, "_addr"}, 64'(got[i][39:32]), 64'(i % DEPTH));
            chk({tag, "_data"}, 64'(got[i][31:0]), 64'(w));
        end
    endtask

    task automatic finish_session(input string tag, input int n);
        int k = 0;
        while (!done && k < 40) begin
            tick;
            k++;
        end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_cpu_rst_in_done"}, {63'd0, cpu_reset}, 64'd1);
        tick;
        chk({tag, "_after_done"}, {61'd0, cpu_reset, done, busy}, 64'd0);
        chk({tag, "_done_pulses"}, 64'(done_cnt - sess_done0), 64'd1);
        verify(tag, n);
    endtask

    task automatic run_session(input string tag, input int n);
        begin_load(n);
        feed(0, 4 * n);
        finish_session(tag, n);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; word_count = '0; rx_data = '0; rx_valid = 1'b0;
        repeat (2) tick;
        chk("reset_vals", {18'd0, rx_ready, im_we, im_addr, im_wdata, busy, done, error, cpu_reset},
            {18'd0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        reset = 1'b1;
        tick;
        chk("idle_cpu_rst", {63'd0, cpu_reset}, 64'd1);

        // Directed two-word program, back-to-back bytes.
        tx_bytes = '{8'h00, 8'h22, 8'h48, 8'h20, 8'h8C, 8'h01, 8'h00, 8'h04};
        tx_gap   = '{0, 0, 0, 0, 0, 0, 0, 0};
        begin_load(2);
        feed(0, 8);
        finish_session("t1", 2);
        if (got_cyc.size() > 0) chk("t1_we_latency", 64'(got_cyc[0] - sess_cyc), 64'd5);
        chk("t1_done_latency", 64'(done_cyc - sess_cyc), 64'd11);

        // Same program with three idle cycles between bytes 1 and 2.
        tx_gap = '{0, 0, 3, 0, 0, 0, 0, 0};
        begin_load(2);
        feed(0, 8);
        finish_session("t2", 2);
        if (got_cyc.size() > 0) chk("t2_we_latency", 64'(got_cyc[0] - sess_cyc), 64'd8);
        chk("t2_done_latency", 64'(done_cyc - sess_cyc), 64'd14);

        // Zero-length load.
        got.delete();
        start = 1'b1; word_count = '0;
        tick;
        start = 1'b0;
        chk("t3_done", {59'd0, done, busy, error, im_we, cpu_reset}, 64'b10001);
        tick;
        chk("t3_after", {62'd0, done, cpu_reset}, 64'd0);
        chk("t3_nwrites", 64'(got.size()), 64'd0);

        // Oversize load is rejected and error is sticky until the next start.
        start = 1'b1; word_count = 9'(DEPTH + 1);
        tick;
        start = 1'b0;
        chk("t4_err", {60'd0, error, cpu_reset, busy, im_we}, 64'b1100);
        repeat (3) tick;
        chk("t4_err_sticky", {62'd0, error, cpu_reset}, 64'b11);
        chk("t4_nwrites", 64'(got.size()), 64'd0);
        gen_tx(1, 2);
        run_session("t4_recover", 1);

        // Reset in the middle of word 1 of a three-word load.
        gen_tx(3, 2);
        begin_load(3);
        feed(0, 6);
        reset = 1'b0;
        #1;
        chk("t5_reset_vals", {18'd0, rx_ready, im_we, im_addr, im_wdata, busy, done, error, cpu_reset},
            {18'd0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        repeat (3) tick;
        verify("t5_partial", 1);
        reset = 1'b1;
        tick;
        gen_tx(2, 1);
        run_session("t5_fresh", 2);

        // start during RECV is ignored.
        gen_tx(3, 1);
        begin_load(3);
        feed(0, 1);
        start = 1'b1; word_count = 9'd5;
        tick;
        start = 1'b0;
        feed(1, 12);
        finish_session("t6", 3);

        // Random lengths and random wait states.
        for (int r = 0; r < 6; r++) begin
            int n = int'($urandom_range(6, 1));
            gen_tx(n, 3);
            run_session("rand", n);
        end

        // Full-depth load reaches the last address.
        gen_tx(DEPTH, 0);
        run_session("full", DEPTH);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
